// File: rtl/rv32_mod_data_memory.sv
// rv32_mod_data_memory: word-organised data memory slave with WAIT_STATES wait cycles and one ack/err per request.
// Define RV32_DMEM_ERR_CHECK_EN to enable range and byte-enable error responses; otherwise addresses alias modulo DEPTH.
module rv32_mod_data_memory #(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        wr,
    input  logic [3:0]  be,
    input  logic [31:0] addr,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack,
    output logic        err,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t        state;
    logic [3:0]    cnt;
    logic [31:0]   mem [DEPTH];
    logic          r_wr, r_err;
    logic [3:0]    r_be;
    logic [AW-1:0] r_idx;
    logic [31:0]   r_data;
    logic [31:0]   offset;
    logic [AW-1:0] idx;
    logic          req_err, capture, enter_resp, s_wr, s_err;
    logic [3:0]    s_be;
    logic [AW-1:0] s_idx;
    logic [31:0]   s_data;
    logic          unused_bits;
    assign offset      = addr - BASE_ADDR;
    assign idx         = offset[AW+1:2];
    assign unused_bits = ^offset;
`ifdef RV32_DMEM_ERR_CHECK_EN
    assign req_err = (offset[31:2] >= 30'(DEPTH)) ||
                     !(be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
`else
    assign req_err = 1'b0;
`endif
    assign busy    = (state != IDLE);
    assign capture = req && (state != WAIT);
    // With no wait states the array is accessed on the capture edge, so take the live request.
    assign enter_resp = (WAIT_STATES == 0) ? capture : (state == WAIT && cnt == 4'd0);
    assign s_wr       = (WAIT_STATES == 0) ? wr      : r_wr;
    assign s_err      = (WAIT_STATES == 0) ? req_err : r_err;
    assign s_be       = (WAIT_STATES == 0) ? be      : r_be;
    assign s_idx      = (WAIT_STATES == 0) ? idx     : r_idx;
    assign s_data     = (WAIT_STATES == 0) ? data_i  : r_data;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            r_wr   <= 1'b0;
            r_err  <= 1'b0;
            r_be   <= '0;
            r_idx  <= '0;
            r_data <= '0;
            ack    <= 1'b0;
            err    <= 1'b0;
            data_o <= '0;
        end else begin
            ack    <= enter_resp && !s_err;
            err    <= enter_resp && s_err;
            data_o <= (enter_resp && !s_wr && !s_err) ? mem[s_idx] : '0;
            if (capture) begin
                r_wr   <= wr;
                r_err  <= req_err;
                r_be   <= be;
                r_idx  <= idx;
                r_data <= data_i;
                cnt    <= CNT_INIT;
                state  <= (WAIT_STATES == 0) ? RESP : WAIT;
            end else if (state == WAIT) begin
                if (cnt == 4'd0)
                    state <= RESP;
                else
                    cnt <= cnt - 4'd1;
            end else if (state == RESP) begin
                state <= IDLE;
            end
        end
    end
    // Array is never reset; writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (reset_n && enter_resp && s_wr && !s_err)
            for (int i = 0; i < 4; i++)
                if (s_be[i])
                    mem[s_idx][8*i +: 8] <= s_data[8*i +: 8];
    end
endmodule

// File: tb/tb_rv32_mod_data_memory.sv
// tb_rv32_mod_data_memory: scoreboard bench over three instances (WAIT_STATES 1, 0, 3).
module tb_rv32_mod_data_memory;
    localparam int WS [3] = '{1, 0, 3};
    typedef struct {
        int          inst;
        int          cyc;
        bit          err;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req   [3];
    logic        wr    [3];
    logic [3:0]  be    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        ack   [3];
    logic        err   [3];
    logic        busy  [3];
    int          cyc = 0;
    int          nvec = 0;
    int          nerr = 0;
    exp_t        sb [$];
    exp_t        e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        rv32_mod_data_memory #(.WAIT_STATES(WS[g])) u_dut (
            .clk    (clk),
            .reset_n(reset_n),
            .req    (req[g]),
            .wr     (wr[g]),
            .be     (be[g]),
            .addr   (addr[g]),
            .data_i (wdata[g]),
            .data_o (rdata[g]),
            .ack    (ack[g]),
            .err    (err[g]),
            .busy   (busy[g])
        );
    end

    // Monitor: every response is matched against the oldest expectation, including its cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ack[i] || err[i]) begin
                nvec++;
                if (sb.size() == 0) begin
                    nerr++;
                    $display("FAIL unexpected_resp inst%0d cyc=%0d: got ack=%b err=%b data=%h, required no response",
                             i, cyc, ack[i], err[i], rdata[i]);
                end else begin
                    e = sb.pop_front();
                    if (e.inst != i || e.cyc != cyc || ack[i] != !e.err || err[i] != e.err || rdata[i] !== e.data) begin
                        nerr++;
                        $display("FAIL resp: got inst%0d ack=%b err=%b data=%h cyc=%0d, required inst%0d ack=%b err=%b data=%h cyc=%0d",
                                 i, ack[i], err[i], rdata[i], cyc, e.inst, !e.err, e.err, e.data, e.cyc);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic issue(input int i, input bit w, input logic [3:0] b, input logic [31:0] a,
                         input logic [31:0] d, input bit ex_err, input logic [31:0] ex_data, input bit resp);
        req[i] = 1'b1; wr[i] = w; be[i] = b; addr[i] = a; wdata[i] = d;
        if (resp) sb.push_back('{inst: i, cyc: cyc + 1 + WS[i], err: ex_err, data: ex_data});
        @(posedge clk); #1;
        req[i] = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        nvec++;
        if (sb.size() != 0) begin
            nerr++;
            $display("FAIL drain_timeout: got %0d pending responses, required 0", sb.size());
            sb.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic xfer(input int i, input bit w, input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] d, input bit ex_err, input logic [31:0] ex_data);
        issue(i, w, b, a, d, ex_err, ex_data, 1'b1);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0; wr[i] = 1'b0; be[i] = '0; addr[i] = '0; wdata[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_ack%0d", i), 32'(ack[i]), 32'd0);
            chk($sformatf("reset_err%0d", i), 32'(err[i]), 32'd0);
            chk($sformatf("reset_busy%0d", i), 32'(busy[i]), 32'd0);
            chk($sformatf("reset_data%0d", i), rdata[i], 32'd0);
        end
        // Basic store/load, one wait state
        xfer(0, 1, 4'b1111, 32'h10, 32'hDEADBEEF, 0, 32'h0);
        xfer(0, 0, 4'b1111, 32'h10, 32'h0, 0, 32'hDEADBEEF);
        xfer(0, 0, 4'b1111, 32'h13, 32'h0, 0, 32'hDEADBEEF);
        // Reset while a store is waiting: no response, no write
        issue(0, 1, 4'b1111, 32'h10, 32'h0BADF00D, 0, 32'h0, 1'b0);
        chk("busy_in_wait", 32'(busy[0]), 32'd1);
        reset_n = 1'b0;
        #1 chk("busy_async_reset", 32'(busy[0]), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        drain();
        xfer(0, 0, 4'b1111, 32'h10, 32'h0, 0, 32'hDEADBEEF);
        // Byte lanes
        xfer(0, 1, 4'b1111, 32'h20, 32'h11223344, 0, 32'h0);
        xfer(0, 1, 4'b0100, 32'h20, 32'hAABBCCDD, 0, 32'h0);
        xfer(0, 0, 4'b1111, 32'h20, 32'h0, 0, 32'h11BB3344);
        xfer(0, 1, 4'b1100, 32'h20, 32'h5566EEFF, 0, 32'h0);
        xfer(0, 0, 4'b1111, 32'h20, 32'h0, 0, 32'h55663344);
        // Back-to-back, zero wait states
        issue(1, 1, 4'b1111, 32'h40, 32'h0000CAFE, 0, 32'h0, 1'b1);
        issue(1, 0, 4'b1111, 32'h40, 32'h0, 0, 32'h0000CAFE, 1'b1);
        drain();
        // Request during WAIT is ignored, three wait states
        issue(2, 1, 4'b1111, 32'h50, 32'h00000077, 0, 32'h0, 1'b1);
        @(posedge clk); #1;
        chk("busy_ws3", 32'(busy[2]), 32'd1);
        issue(2, 1, 4'b1111, 32'h50, 32'h00000099, 0, 32'h0, 1'b0);
        drain();
        xfer(2, 0, 4'b1111, 32'h50, 32'h0, 0, 32'h00000077);
`ifdef RV32_DMEM_ERR_CHECK_EN
        xfer(0, 0, 4'b1111, 32'h1000, 32'h0, 1, 32'h0);
        xfer(0, 1, 4'b0101, 32'h20, 32'hFFFFFFFF, 1, 32'h0);
        xfer(0, 1, 4'b0110, 32'h20, 32'hFFFFFFFF, 1, 32'h0);
        xfer(0, 1, 4'b0000, 32'h20, 32'hFFFFFFFF, 1, 32'h0);
        xfer(0, 1, 4'b1111, 32'h1000, 32'hFFFFFFFF, 1, 32'h0);
        xfer(0, 0, 4'b1111, 32'h20, 32'h0, 0, 32'h55663344);
`else
        xfer(0, 1, 4'b1111, 32'h1000, 32'h12345678, 0, 32'h0);
        xfer(0, 0, 4'b1111, 32'h0, 32'h0, 0, 32'h12345678);
        xfer(0, 1, 4'b0000, 32'h0, 32'hFFFFFFFF, 0, 32'h0);
        xfer(0, 1, 4'b0101, 32'h20, 32'hAA00BB00, 0, 32'h0);
        xfer(0, 0, 4'b1111, 32'h1000, 32'h0, 0, 32'h12345678);
        xfer(0, 0, 4'b1111, 32'h20, 32'h0, 0, 32'h55003300);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
